// File: rtl/ps2_amount_entry.sv
// ps2_amount_entry
//   Receives PS/2 keyboard frames and turns hex-digit, Enter, Space and
//   Backspace make-codes into an 8-bit entry value plus load/start strobes.
//
// Ports
//   clock        in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   ps2_clk      in   raw PS/2 clock (asynchronous)
//   ps2_data     in   raw PS/2 data (asynchronous)
//   value        out  [7:0] assembled entry, held between keystrokes
//   digit_count  out  [1:0] digits in the current entry, saturates at 2
//   load_pulse   out  one-cycle pulse on Enter (main or keypad)
//   start_pulse  out  one-cycle pulse on Space
//   frame_error  out  one-cycle pulse on bad start/parity/stop bit or timeout
//
// Handshake: there is no backpressure. The receiver raises an internal
// byte_valid strobe for exactly one cycle per good frame and the decoder
// consumes it in that same cycle; every output pulse is exactly one cycle.
module ps2_amount_entry #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] value,
    output logic [1:0] digit_count,
    output logic       load_pulse,
    output logic       start_pulse,
    output logic       frame_error
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic          sample;     // one cycle per filtered falling edge
    logic          data_bit;   // data captured with that edge

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // The filtered level flips only after the synchronized clock has shown
    // the opposite level on FILTER_LEN consecutive edges.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            sample     <= 1'b0;
            data_bit   <= 1'b1;
        end else begin
            sample <= 1'b0;
            if (clk_s2 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_cnt   <= '0;
                filt_level <= clk_s2;
                if (filt_level) begin
                    sample   <= 1'b1;
                    data_bit <= data_s2;
                end
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          byte_valid, byte_valid_n;
    logic          rx_err_n;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par         <= 1'b0;
            tcnt        <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            par         <= par_n;
            tcnt        <= tcnt_n;
            byte_valid  <= byte_valid_n;
            frame_error <= rx_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_n        = par;
        tcnt_n       = tcnt;
        byte_valid_n = 1'b0;
        rx_err_n     = 1'b0;

        if (sample)
            tcnt_n = '0;
        else if (state != IDLE)
            tcnt_n = tcnt + TW'(1);

        case (state)
            IDLE: begin
                if (sample) begin
                    if (!data_bit) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        rx_err_n = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_n   = {data_bit, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state_n = PARITY;
                end
            end
            PARITY: begin
                if (sample) begin
                    par_n   = data_bit;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    // Odd parity: data plus parity bit carry an odd count of ones.
                    if (data_bit && (^{shift, par}))
                        byte_valid_n = 1'b1;
                    else
                        rx_err_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A stalled frame is abandoned; partial bits are dropped.
        if (!sample && state != IDLE && tcnt == TW'(TIMEOUT - 1)) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            shift_n   = '0;
            tcnt_n    = '0;
            rx_err_n  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code decoder
    // ------------------------------------------------------------------
    // Returns {is_digit, nibble}.
    function automatic logic [4:0] digit_of(input logic [7:0] code);
        case (code)
            8'h45: digit_of = 5'h10;
            8'h16: digit_of = 5'h11;
            8'h1E: digit_of = 5'h12;
            8'h26: digit_of = 5'h13;
            8'h25: digit_of = 5'h14;
            8'h2E: digit_of = 5'h15;
            8'h36: digit_of = 5'h16;
            8'h3D: digit_of = 5'h17;
            8'h3E: digit_of = 5'h18;
            8'h46: digit_of = 5'h19;
            8'h1C: digit_of = 5'h1A;
            8'h32: digit_of = 5'h1B;
            8'h21: digit_of = 5'h1C;
            8'h23: digit_of = 5'h1D;
            8'h24: digit_of = 5'h1E;
            8'h2B: digit_of = 5'h1F;
            default: digit_of = 5'h00;
        endcase
    endfunction

    logic       brk, ext, fresh;
    logic [4:0] dig;

    assign dig = digit_of(shift);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            brk         <= 1'b0;
            ext         <= 1'b0;
            fresh       <= 1'b0;
            value       <= 8'h00;
            digit_count <= 2'd0;
            load_pulse  <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            load_pulse  <= 1'b0;
            start_pulse <= 1'b0;
            if (byte_valid) begin
                if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (!brk) begin
                        if (ext) begin
                            // Only keypad Enter is meaningful among extended codes.
                            if (shift == 8'h5A) begin
                                load_pulse <= 1'b1;
                                fresh      <= 1'b1;
                            end
                        end else if (shift == 8'h5A) begin
                            load_pulse <= 1'b1;
                            fresh      <= 1'b1;
                        end else if (shift == 8'h29) begin
                            start_pulse <= 1'b1;
                        end else if (shift == 8'h66) begin
                            value <= {4'h0, value[7:4]};
                            if (digit_count != 2'd0)
                                digit_count <= digit_count - 2'd1;
                        end else if (dig[4]) begin
                            if (fresh) begin
                                value       <= {4'h0, dig[3:0]};
                                digit_count <= 2'd1;
                                fresh       <= 1'b0;
                            end else begin
                                value <= {value[3:0], dig[3:0]};
                                if (digit_count != 2'd2)
                                    digit_count <= digit_count + 2'd1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_amount_entry.sv
module tb_ps2_amount_entry;

  localparam int FILT = 8;
  localparam int TO   = 2000;
  localparam int HALF = 25;   // clocks per PS/2 clock half-period

  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_START = 2'd2;
  localparam logic [1:0] K_ERR   = 2'd3;

  logic       clock;
  logic       resetn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] value;
  logic [1:0] digit_count;
  logic       load_pulse;
  logic       start_pulse;
  logic       frame_error;

  int checks;
  int failures;
  int last_lat;

  // {pulse kind, value expected while the pulse is high}
  logic [9:0] exp_q[$];

  ps2_amount_entry #(.FILTER_LEN(FILT), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .value       (value),
    .digit_count (digit_count),
    .load_pulse  (load_pulse),
    .start_pulse (start_pulse),
    .frame_error (frame_error)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard: every pulse must match the head of the expected queue
  always @(negedge clock) begin : monitor
    logic [9:0] got;
    logic [9:0] exp;
    if (load_pulse || start_pulse || frame_error) begin
      checks++;
      if ((int'(load_pulse) + int'(start_pulse) + int'(frame_error)) > 1) begin
        failures++;
        $display("FAIL pulse_overlap load=%0b start=%0b err=%0b", load_pulse, start_pulse, frame_error);
      end else begin
        got = {(load_pulse ? K_LOAD : (start_pulse ? K_START : K_ERR)), value};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse got kind=%0d value=%h, none expected", got[9:8], got[7:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL pulse got kind=%0d value=%h expected kind=%0d value=%h",
                     got[9:8], got[7:0], exp[9:8], exp[7:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    // stop bit: record clocks from the falling edge to the first pulse
    ps2_data = 1'b1;
    wait_clks(HALF);
    ps2_clk  = 1'b0;
    last_lat = -1;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clock);
      if ((load_pulse || start_pulse || frame_error) && last_lat < 0) last_lat = i;
    end
    ps2_clk = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    wait_clks(5);
    resetn = 1'b1;
    wait_clks(5);
  endtask

  // scenarios
  task automatic test_reset();
    resetn   = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(4);
    checks++;
    if ({value, digit_count, load_pulse, start_pulse, frame_error} !== 13'd0) begin
      failures++;
      $display("FAIL reset_state got value=%h cnt=%0d pulses=%b%b%b expected all zero",
               value, digit_count, load_pulse, start_pulse, frame_error);
    end
    resetn = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_digits_enter();
    send_frame(8'h1E, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h02, 2'd1}) begin
      failures++;
      $display("FAIL digit_1E got %h/%0d expected 02/1", value, digit_count);
    end
    send_frame(8'h2B, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h2F, 2'd2}) begin
      failures++;
      $display("FAIL digit_2B got %h/%0d expected 2F/2", value, digit_count);
    end
    exp_q.push_back({K_LOAD, 8'h2F});
    send_frame(8'h5A, 1'b0);
    checks++;
    if (last_lat !== 2 + FILT + 2) begin
      failures++;
      $display("FAIL load_latency got %0d expected %0d", last_lat, 2 + FILT + 2);
    end
    checks++;
    if ({value, digit_count} !== {8'h2F, 2'd2}) begin
      failures++;
      $display("FAIL after_enter got %h/%0d expected 2F/2", value, digit_count);
    end
  endtask

  task automatic test_backspace_break();
    send_frame(8'h16, 1'b0);
    send_frame(8'h26, 1'b0);
    send_frame(8'h25, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h34, 2'd2}) begin
      failures++;
      $display("FAIL third_digit got %h/%0d expected 34/2", value, digit_count);
    end
    send_frame(8'h66, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h03, 2'd1}) begin
      failures++;
      $display("FAIL backspace got %h/%0d expected 03/1", value, digit_count);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h25, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h03, 2'd1}) begin
      failures++;
      $display("FAIL break_code got %h/%0d expected 03/1", value, digit_count);
    end
  endtask

  task automatic test_fresh();
    apply_reset();
    send_frame(8'h45, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h00, 2'd1}) begin
      failures++;
      $display("FAIL digit_0 got %h/%0d expected 00/1", value, digit_count);
    end
    exp_q.push_back({K_LOAD, 8'h00});
    send_frame(8'h5A, 1'b0);
    send_frame(8'h3D, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h07, 2'd1}) begin
      failures++;
      $display("FAIL fresh_restart got %h/%0d expected 07/1", value, digit_count);
    end
  endtask

  task automatic test_parity();
    apply_reset();
    exp_q.push_back({K_ERR, 8'h00});
    send_frame(8'h16, 1'b1);
    checks++;
    if ({value, digit_count} !== {8'h00, 2'd0}) begin
      failures++;
      $display("FAIL bad_parity got %h/%0d expected 00/0", value, digit_count);
    end
    send_frame(8'h16, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h01, 2'd1}) begin
      failures++;
      $display("FAIL after_parity got %h/%0d expected 01/1", value, digit_count);
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back({K_ERR, 8'h01});
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    wait_clks(TO + 100);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL timeout_error got pending=%0d expected 0", exp_q.size());
    end
    exp_q.push_back({K_START, 8'h01});
    send_frame(8'h29, 1'b0);
    checks++;
    if (exp_q.size() !== 0 || {value, digit_count} !== {8'h01, 2'd1}) begin
      failures++;
      $display("FAIL space_after_timeout got pending=%0d %h/%0d expected 0 01/1",
               exp_q.size(), value, digit_count);
    end
  endtask

  task automatic test_ext_saturation();
    apply_reset();
    send_frame(8'h66, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h00, 2'd0}) begin
      failures++;
      $display("FAIL backspace_empty got %h/%0d expected 00/0", value, digit_count);
    end
    exp_q.push_back({K_LOAD, 8'h00});
    send_frame(8'h5A, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h16, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h00, 2'd0}) begin
      failures++;
      $display("FAIL ext_digit got %h/%0d expected 00/0", value, digit_count);
    end
    send_frame(8'h16, 1'b0);
    exp_q.push_back({K_LOAD, 8'h01});
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    checks++;
    if (exp_q.size() !== 0 || {value, digit_count} !== {8'h01, 2'd1}) begin
      failures++;
      $display("FAIL keypad_enter got pending=%0d %h/%0d expected 0 01/1",
               exp_q.size(), value, digit_count);
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h1E, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h02, 2'd1}) begin
      failures++;
      $display("FAIL pre_reset got %h/%0d expected 02/1", value, digit_count);
    end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(3);
    resetn = 1'b0;
    #1;
    checks++;
    if ({value, digit_count, load_pulse, start_pulse, frame_error} !== 13'd0) begin
      failures++;
      $display("FAIL async_reset got value=%h cnt=%0d pulses=%b%b%b expected all zero",
               value, digit_count, load_pulse, start_pulse, frame_error);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(5);
    resetn = 1'b1;
    wait_clks(TO + 100);
    checks++;
    if ({value, digit_count} !== {8'h00, 2'd0}) begin
      failures++;
      $display("FAIL post_reset got %h/%0d expected 00/0", value, digit_count);
    end
  endtask

  task automatic test_glitch();
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_clks(FILT - 1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    // a false sample would start a frame that later times out with an error
    wait_clks(TO + 100);
    send_frame(8'h16, 1'b0);
    checks++;
    if ({value, digit_count} !== {8'h01, 2'd1}) begin
      failures++;
      $display("FAIL after_glitch got %h/%0d expected 01/1", value, digit_count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    last_lat = -1;
    test_reset();
    test_digits_enter();
    test_backspace_break();
    test_fresh();
    test_parity();
    test_timeout();
    test_ext_saturation();
    test_reset_midframe();
    test_glitch();
    wait_clks(20);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL pending_pulses got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_amount_entry.md
# ps2_amount_entry

Receives PS/2 keyboard frames, decodes hexadecimal digit, Enter, Space and Backspace make-codes, and assembles an 8-bit entry value. It sits upstream of `main_control` and `datapath`, replacing the switch/pushbutton entry path. `value` drives the amount/key inputs, `load_pulse` drives the load signal, and `start_pulse` drives the start signal. All outputs are synchronous to the system clock.

## Interface
- `FILTER_LEN`, default 8: number of consecutive clocks the synchronized `ps2_clk` must hold a new level before the filtered level changes.
- `TIMEOUT`, default 50000: number of clocks without a filtered falling edge, while mid-frame, before the frame is abandoned.
- `clock`  in  1  system clock (CLOCK_50); all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clock`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clock`.
- `value`  out  8  assembled entry; holds its value between keystrokes.
- `digit_count`  out  2  digits in the current entry; saturates at 2.
- `load_pulse`  out  1  one-cycle pulse on Enter.
- `start_pulse`  out  1  one-cycle pulse on Space.
- `frame_error`  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through 2-FF synchronizers. The synchronized `ps2_clk` passes through the `FILTER_LEN` stability filter; the filtered level resets to 1. A filtered 1→0 transition is a sample event.
- **Receiver FSM, states IDLE, DATA, PARITY, STOP:**
  - IDLE: on a sample event with data 0, go to DATA. A start bit of 1 pulses `frame_error` and the FSM stays in IDLE.
  - DATA: shift in 8 bits, LSB first, on 8 sample events, then go to PARITY.
  - PARITY: the odd-parity bit is sampled and checked; go to STOP.
  - STOP: a stop bit of 1 with good parity makes the byte valid. Any failure pulses `frame_error` and discards the byte. Return to IDLE either way.
- **Timeout:** a counter clears on every sample event and counts only outside IDLE. Reaching `TIMEOUT` returns the FSM to IDLE, discards partial bits and pulses `frame_error`.
- **Decoder (on a valid byte):**
  - F0 sets `brk`. E0 sets `ext`.
  - Any other byte is a code. If `brk` is set, the code is ignored. Both flags clear after any code.
  - With `ext` set, only 5A (keypad Enter) is acted on.
- **Digit codes:** 45,16,1E,26,25,2E,36,3D,3E,46 map to 0–9; 1C,32,21,23,24,2B map to A–F.
  - Digit action: `value <= {value[3:0], nibble}` and `digit_count` increments, saturating at 2. A third digit keeps shifting, so the last two digits are retained.
  - If `fresh` is set, the digit instead sets `value <= {4'h0, nibble}` and `digit_count <= 1`, and clears `fresh`.
- **Command codes:**
  - 5A (Enter): `load_pulse` and `fresh` set; `value` is unchanged. Enter with `digit_count`=0 still pulses, with `value` as held.
  - 29 (Space): `start_pulse`; entry unchanged.
  - 66 (Backspace): `value <= {4'h0, value[7:4]}` and `digit_count` decrements, saturating at 0.
  - All other codes are ignored.
- **Reset:** asynchronous assertion, including mid-frame, forces:
  - FSM to IDLE; bit count, timeout counter, `brk`, `ext` and `fresh` to 0.
  - `value`=8'h00, `digit_count`=0, all pulses 0.
  - Filter level to 1 and synchronizers to 1.

## Timing
- Synchronizer latency is 2 cycles; the filter adds `FILTER_LEN` cycles.
- Let cycle S be the sample event of the stop bit.
  - The byte-valid strobe is registered at S+1.
  - `value`, `digit_count`, `load_pulse`, `start_pulse` and the flag updates are registered at S+2.
  - `frame_error` for a bad parity or stop bit is registered at S+1.
- `value` is stable on the cycle `load_pulse` is high and stays stable until the next digit or Backspace. Downstream logic may sample `value` while `load_pulse` is high.
- Pulses are exactly one cycle wide. `load_pulse` and `start_pulse` are never asserted in the same cycle, since one code is decoded per byte.
- Maximum decode rate is one byte per frame (≥ 11 sample events); there is no backpressure.

## Test plan
- Frames 1E, 2B, 5A (`FILTER_LEN`=8, sample events ≥ 40 clocks apart) → `value`=8'h2F, `digit_count`=2, one `load_pulse` 2 clocks after the Enter stop-bit sample.
- Frames 16, 26, 25, 66 → `value`=8'h03, `digit_count`=1. Then F0, 25 → no change.
- Frames 45, 5A, 3D → after Enter `value`=8'h00; after 3D `value`=8'h07, `digit_count`=1 (fresh restart).
- Frame 16 with a corrupted parity bit → `frame_error` pulses once, `value` unchanged. A following valid 16 → `value`=8'h01.
- Stop `ps2_clk` after 4 data bits for `TIMEOUT` clocks → `frame_error` pulses and the FSM is in IDLE. The next full 29 frame → one `start_pulse`.
- `resetn` low mid-frame after 1E was accepted → `value`=0, `digit_count`=0, no pulses. Glitch `ps2_clk` low for `FILTER_LEN`-1 clocks → no sample event.
